// File: rtl/rsa_pkg.sv
// Shared types and sizing for the modular-exponentiation engine.
// DW is the operand width (two primes' worth), PW the full product width.
package rsa_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DW        = 2 * DEF_WIDTH;
    localparam int PW        = 4 * DEF_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXP
    } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Combinational modular multiply: m = (a*b) mod n, with x mod 0 defined as 0.
// Zero latency; no flow control.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic [2*WIDTH-1:0] n,
    output logic [2*WIDTH-1:0] m
);

    localparam int OP_W   = 2 * WIDTH;
    localparam int PROD_W = 4 * WIDTH;

    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] n_ext;

    // Full-width product so nothing is lost before the reduction.
    assign prod  = PROD_W'(a) * PROD_W'(b);
    assign n_ext = PROD_W'(n);

    always_comb begin
        m = '0;
        if (n != '0) begin
            m = OP_W'(prod % n_ext);
        end
    end

endmodule

// File: rtl/rsa_modexp.sv
// Right-to-left square-and-multiply modexp: out_m = in_c^in_d mod in_n.
// Fixed latency 2*WIDTH+2 cycles from in_valid to out_valid; in_valid ignored while busy.
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2*WIDTH-1:0]   in_n,
    input  logic [2*WIDTH-1:0]   in_d,
    input  logic [2*WIDTH-1:0]   in_c,
    output logic                 busy,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_m
);

    localparam int OP_W  = 2 * WIDTH;
    localparam int CNT_W = $clog2(OP_W + 1);

    state_t            state_q;
    state_t            state_d;
    logic [OP_W-1:0]   n_q;
    logic [OP_W-1:0]   exp_q;
    logic [OP_W-1:0]   base_q;
    logic [OP_W-1:0]   res_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [OP_W-1:0]   sq_a;
    logic [OP_W-1:0]   mul_p;
    logic [OP_W-1:0]   sq_p;
    logic [OP_W-1:0]   res_next;
    logic              last_bit;

    // In LOAD the multipliers perform the initial reductions: c*1 mod n and 1*1 mod n.
    always_comb begin
        mul_a = res_q;
        mul_b = base_q;
        sq_a  = base_q;
        if (state_q == LOAD) begin
            mul_a = base_q;
            mul_b = OP_W'(1);
            sq_a  = OP_W'(1);
        end
    end

    rsa_modmul #(.WIDTH(WIDTH)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .n (n_q),
        .m (mul_p)
    );

    rsa_modmul #(.WIDTH(WIDTH)) u_sq (
        .a (sq_a),
        .b (sq_a),
        .n (n_q),
        .m (sq_p)
    );

    assign res_next = exp_q[0] ? mul_p : res_q;
    assign last_bit = (state_q == EXP) && (cnt_q == CNT_W'(OP_W - 1));
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LOAD;
            LOAD:    state_d = EXP;
            EXP:     if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The base register holds the raw ciphertext until LOAD reduces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q       <= '0;
            exp_q     <= '0;
            base_q    <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_m     <= '0;
        end else begin
            out_valid <= 1'b0;
            out_m     <= '0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        n_q    <= in_n;
                        exp_q  <= in_d;
                        base_q <= in_c;
                    end
                end
                LOAD: begin
                    base_q <= mul_p;
                    res_q  <= sq_p;
                    cnt_q  <= '0;
                end
                EXP: begin
                    res_q  <= res_next;
                    base_q <= sq_p;
                    exp_q  <= exp_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        out_valid <= 1'b1;
                        out_m     <= res_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
